// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, in_a, in_b,
        input  busy, done, sum_out, carry_out
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, in_a, in_b,
        output busy, done, sum_out, carry_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders + OR) reused per bit.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on start
// ADD   | one bit pair summed per clock, LSB first
// DONE  | result valid, done pulses for this single cycle
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    serial_add_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;

    logic ha0_s;
    logic ha0_c;
    logic sum_bit;
    logic ha1_c;
    logic carry_next;

    half_adder u_ha0 (.a(sh_a[0]), .b(sh_b[0]), .s(ha0_s),   .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),   .b(carry),   .s(sum_bit), .c(ha1_c));
    assign carry_next = ha0_c | ha1_c;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            carry         <= 1'b0;
            sh_a          <= '0;
            sh_b          <= '0;
            res           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum_out   <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sh_a     <= bus.in_a;
`ifdef SERIAL_ADD_SUB_EN
                        // two's complement subtract: invert B and inject a carry
                        sh_b     <= bus.sub ? ~bus.in_b : bus.in_b;
                        carry    <= bus.sub;
`else
                        sh_b     <= bus.in_b;
                        carry    <= 1'b0;
`endif
                        res      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= {sum_bit, res[WIDTH-1:1]};
                    carry <= carry_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        bus.sum_out   <= {sum_bit, res[WIDTH-1:1]};
                        bus.carry_out <= carry_next;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   failures;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: start for one cycle, scramble operands after accept,
    // then check latency, busy length, held outputs, result and pulse width.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_c);
        logic [7:0] prev_sum;
        logic       prev_c;
        int         lat;
        int         busy_cyc;
        int         held_ok;
        @(negedge sys_clk);
        prev_sum  = bus.sum_out;
        prev_c    = bus.carry_out;
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.in_b  = b;
        @(negedge sys_clk);
        bus.start = 1'b0;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        lat = 0;
        busy_cyc = 0;
        held_ok = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.sum_out !== prev_sum || bus.carry_out !== prev_c) held_ok = 0;
            @(negedge sys_clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, busy_cyc, 8);
        chk({tag, "_held"}, held_ok, 1);
        chk({tag, "_sum"}, bus.sum_out, exp_sum);
        chk({tag, "_carry"}, bus.carry_out, exp_c);
        @(negedge sys_clk);
        chk({tag, "_done_one_cycle"}, {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        int n_done;
        int last;
        logic [7:0] seen_sum;
        checks = 0;
        failures = 0;
        sys_rst_n = 1'b0;
        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(negedge sys_clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.sum_out, bus.carry_out}, 11'd0);
        sys_rst_n = 1'b1;

        do_op("t1", 8'h35, 8'h4A, 8'h7F, 1'b0);
        do_op("t2", 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op("add_80_80", 8'h80, 8'h80, 8'h00, 1'b1);
        do_op("add_a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);

        // start pulse while busy must be ignored
        @(negedge sys_clk);
        bus.start = 1'b1; bus.in_a = 8'h10; bus.in_b = 8'h20;
        @(negedge sys_clk);
        bus.start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        bus.start = 1'b1; bus.in_a = 8'hAA;
        @(negedge sys_clk);
        bus.start = 1'b0;
        n_done = 0;
        seen_sum = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            if (bus.done === 1'b1) begin
                n_done++;
                seen_sum = bus.sum_out;
            end
            @(negedge sys_clk);
        end
        chk("t3_done_pulses", n_done, 1);
        chk("t3_sum", seen_sum, 8'h30);

        // reset mid-operation aborts with no done
        @(negedge sys_clk);
        bus.start = 1'b1; bus.in_a = 8'h0F; bus.in_b = 8'h01;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("t4_reset_outputs", {bus.busy, bus.done, bus.sum_out, bus.carry_out}, 11'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (i == 2) sys_rst_n = 1'b1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        chk("t4_no_done_after_abort", n_done, 0);
        do_op("t4_after_reset", 8'h01, 8'h01, 8'h02, 1'b0);

        // start held high: back-to-back ops every WIDTH+2 cycles
        @(negedge sys_clk);
        bus.start = 1'b1; bus.in_a = 8'h03; bus.in_b = 8'h04;
        n_done = 0;
        last = -1;
        for (int i = 0; i < 35; i++) begin
            @(negedge sys_clk);
            if (bus.done === 1'b1) begin
                chk("t5_sum", bus.sum_out, 8'h07);
                if (last >= 0) chk("t5_period", i - last, 10);
                last = i;
                n_done++;
            end
        end
        chk("t5_pulse_count", n_done, 3);
        bus.start = 1'b0;
        repeat (12) @(negedge sys_clk);

`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b1;
        do_op("t6_0a_minus_14", 8'h0A, 8'h14, 8'hF6, 1'b0);
        do_op("t6_14_minus_0a", 8'h14, 8'h0A, 8'h0A, 1'b1);
        bus.sub = 1'b0;
        do_op("t6_add_again", 8'h14, 8'h0A, 8'h1E, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
